// File: rtl/letreiro_pkg.sv
// rtl/letreiro_pkg.sv - symbol codes, FSM states and message ROM for the marquee source
package letreiro_pkg;

    localparam logic [2:0] COD_A      = 3'b000;
    localparam logic [2:0] COD_B      = 3'b001;
    localparam logic [2:0] COD_R      = 3'b010;
    localparam logic [2:0] COD_I      = 3'b011;
    localparam logic [2:0] COD_E      = 3'b100;
    localparam logic [2:0] COD_L      = 3'b101;
    localparam logic [2:0] COD_ESPACO = 3'b110;
    localparam logic [2:0] COD_G      = 3'b111;

    localparam int MSG_LEN = 8;

    typedef enum logic {
        PARADO  = 1'b0,
        RODANDO = 1'b1
    } estado_t;

    // "gabriel " indexed by circular position
    function automatic logic [2:0] msg_codigo(input logic [2:0] idx);
        logic [2:0] cod;
        case (idx)
            3'd0:    cod = COD_G;
            3'd1:    cod = COD_A;
            3'd2:    cod = COD_B;
            3'd3:    cod = COD_R;
            3'd4:    cod = COD_I;
            3'd5:    cod = COD_E;
            3'd6:    cod = COD_L;
            default: cod = COD_ESPACO;
        endcase
        return cod;
    endfunction

endpackage

// File: rtl/letreiro_divisor.sv
// rtl/letreiro_divisor.sv - auto-scroll prescaler, cleared whenever the run state changes
module letreiro_divisor #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic habilita,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic         ativo;
    logic [W-1:0] cnt;

    // ativo mirrors the top FSM: running iff habilita was high last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ativo <= 1'b0;
            cnt   <= '0;
        end else begin
            ativo <= habilita;
            if (!ativo || !habilita) begin
                cnt <= '0;
            end else if (cnt == W'(DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = ativo && (cnt == W'(DIV - 1));

endmodule

// File: rtl/letreiro_gerador.sv
// rtl/letreiro_gerador.sv - scrolling "gabriel " code generator driving per-display decoders
module letreiro_gerador
    import letreiro_pkg::*;
#(
    parameter int N_DISPLAYS = 4,
    parameter int DIV        = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    habilita,
    input  logic                    direcao,
    input  logic                    passo,
    output logic [3*N_DISPLAYS-1:0] codigos,
    output logic [2:0]              posicao,
    output logic                    avanco
);

    estado_t estado, estado_prox;
    logic    passo_q;
    logic    tick;
    logic    avancar;

    letreiro_divisor #(.DIV(DIV)) u_divisor (
        .clk      (clk),
        .rst      (rst),
        .habilita (habilita),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= PARADO;
            posicao <= 3'd0;
            passo_q <= 1'b0;
            avanco  <= 1'b0;
        end else begin
            estado  <= estado_prox;
            passo_q <= passo;
            avanco  <= avancar;
            if (avancar) begin
                posicao <= direcao ? posicao - 3'd1 : posicao + 3'd1;
            end
        end
    end

    // a step coinciding with habilita rising is dropped because the next state is RODANDO
    always_comb begin
        estado_prox = habilita ? RODANDO : PARADO;
        avancar     = 1'b0;
        case (estado)
            PARADO:  avancar = !habilita && passo && !passo_q;
            RODANDO: avancar = tick;
            default: avancar = 1'b0;
        endcase
    end

    for (genvar k = 0; k < N_DISPLAYS; k++) begin : g_disp
        assign codigos[3*k +: 3] = msg_codigo(posicao + 3'(k));
    end

endmodule

// File: tb/tb_letreiro_gerador.sv
// tb/tb_letreiro_gerador.sv - directed self-checking bench for letreiro_gerador
module tb_letreiro_gerador;

    logic        clk = 1'b0;
    logic        rst;
    logic        habilita;
    logic        direcao;
    logic        passo;
    logic [11:0] codigos;
    logic [2:0]  posicao;
    logic        avanco;

    int total = 0;
    int bad   = 0;
    int pulsos;

    letreiro_gerador #(.N_DISPLAYS(4), .DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .habilita (habilita),
        .direcao  (direcao),
        .passo    (passo),
        .codigos  (codigos),
        .posicao  (posicao),
        .avanco   (avanco)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic conta_pulsos(input int n);
        pulsos = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (avanco) pulsos++;
        end
    endtask

    initial begin
        rst = 1'b1; habilita = 1'b0; direcao = 1'b0; passo = 1'b0;
        ciclos(3);
        rst = 1'b0;
        chk("rst_codigos", 32'(codigos), 32'h447);
        chk("rst_posicao", 32'(posicao), 0);
        chk("rst_avanco", 32'(avanco), 0);
        conta_pulsos(20);
        chk("idle_pulsos", pulsos, 0);
        chk("idle_posicao", 32'(posicao), 0);

        // auto scroll left: transition edge, then advance on 4th edge
        habilita = 1'b1;
        ciclos(1);
        ciclos(3);
        chk("left_before", 32'(posicao), 0);
        ciclos(1);
        chk("left_posicao", 32'(posicao), 1);
        chk("left_codigos", 32'(codigos), 32'h688);
        chk("left_avanco", 32'(avanco), 1);
        ciclos(1);
        chk("left_avanco_low", 32'(avanco), 0);
        conta_pulsos(27);
        chk("wrap_pulsos", pulsos, 7);
        chk("wrap_posicao", 32'(posicao), 0);
        chk("wrap_codigos", 32'(codigos), 32'h447);

        // paused, held step moving right from 0 wraps to 7 once
        habilita = 1'b0; direcao = 1'b1;
        ciclos(1);
        chk("pause_posicao", 32'(posicao), 0);
        passo = 1'b1;
        conta_pulsos(10);
        passo = 1'b0;
        chk("hold_pulsos", pulsos, 1);
        chk("hold_posicao", 32'(posicao), 7);
        chk("hold_codigos", 32'(codigos), 32'h23E);
        ciclos(1);

        // four single steps left: 7 -> 3
        direcao = 1'b0;
        for (int i = 0; i < 4; i++) begin
            passo = 1'b1; ciclos(1);
            passo = 1'b0; ciclos(1);
        end
        chk("steps_posicao", 32'(posicao), 3);

        // direction flipped at prescaler count 2
        habilita = 1'b1;
        ciclos(3);
        direcao = 1'b1;
        ciclos(1);
        chk("flip_before", 32'(posicao), 3);
        ciclos(1);
        chk("flip_posicao", 32'(posicao), 2);
        ciclos(3);
        chk("flip_spacing", 32'(posicao), 2);
        ciclos(1);
        chk("flip_next", 32'(posicao), 1);
        chk("flip_avanco", 32'(avanco), 1);

        // habilita 1->0->1 at count 2 with passo activity while running
        ciclos(2);
        passo = 1'b1; habilita = 1'b0;
        ciclos(1);
        passo = 1'b0; habilita = 1'b1;
        ciclos(1);
        chk("toggle_posicao", 32'(posicao), 1);
        passo = 1'b1;
        ciclos(1);
        passo = 1'b0;
        ciclos(2);
        chk("toggle_before", 32'(posicao), 1);
        ciclos(1);
        chk("toggle_posicao2", 32'(posicao), 0);
        chk("toggle_avanco", 32'(avanco), 1);

        // reset when an advance is due
        ciclos(4);
        chk("pre_rst_posicao", 32'(posicao), 7);
        ciclos(3);
        rst = 1'b1;
        #1;
        chk("arst_posicao", 32'(posicao), 0);
        chk("arst_codigos", 32'(codigos), 32'h447);
        chk("arst_avanco", 32'(avanco), 0);
        habilita = 1'b0;
        ciclos(1);
        rst = 1'b0;
        conta_pulsos(6);
        chk("post_rst_pulsos", pulsos, 0);
        chk("post_rst_posicao", 32'(posicao), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
